// File: rtl/flit_serializer_pkg.sv
// Shared types for the flit serializer: flit format, packet element, FSM states.
// Optional stall timeout is enabled by defining FLIT_SERIALIZER_TIMEOUT_EN.
package flit_serializer_pkg;

  localparam int unsigned PKT_BUF_ENTRIES = 8;
  localparam int unsigned FLIT_ID_W       = 4;
  localparam int unsigned FLIT_PAYLOAD_W  = 32;
  localparam int unsigned PACKET_ID_W     = 8;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    TAIL = 2'd2
  } flittype_e;

  typedef struct packed {
    flittype_e                 flittype;
    logic [FLIT_ID_W-1:0]      flit_id;
    logic [FLIT_PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef logic [PACKET_ID_W-1:0] packet_id_t;

  // Wide enough to hold PKT_BUF_ENTRIES itself, so out-of-range tails are representable.
  typedef logic [$clog2(PKT_BUF_ENTRIES+1)-1:0] tail_index_t;

  typedef struct packed {
    packet_id_t                    packet_id;
    logic                          is_complete;
    tail_index_t                   tail_index;
    flit_t [PKT_BUF_ENTRIES-1:0]   buffer;
  } packet_element_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } serializer_state_t;

endpackage

// File: rtl/flit_serializer_if.sv
// Packet-in / flit-out handshake bundle; master is the serializer, slave is its environment.
interface flit_serializer_if;
  import flit_serializer_pkg::*;

  packet_element_t packet;
  logic            packet_valid;
  logic            packet_ready;
  flit_t           flit;
  logic            flit_valid;
  logic            flit_ready;
  logic            packet_sent;
  packet_id_t      sent_pkt_id;
  logic            tx_error;

  modport master (
    input  packet, packet_valid, flit_ready,
    output packet_ready, flit, flit_valid, packet_sent, sent_pkt_id, tx_error
  );

  modport slave (
    output packet, packet_valid, flit_ready,
    input  packet_ready, flit, flit_valid, packet_sent, sent_pkt_id, tx_error
  );

endinterface

// File: rtl/flit_serializer.sv
// Captures one complete packet and streams its flits in index order over valid/ready.
// Define FLIT_SERIALIZER_TIMEOUT_EN to abort a packet after TIMEOUT_CYCLES stalled cycles.
module flit_serializer
  import flit_serializer_pkg::*;
#(
  parameter int unsigned PACKET_BUFFER_NUM_ENTRIES = PKT_BUF_ENTRIES,
  parameter int unsigned TIMEOUT_CYCLES            = 64
) (
  input logic               nocclk,
  input logic               rst_n,
  flit_serializer_if.master bus
);

  localparam int unsigned SEL_W = (PACKET_BUFFER_NUM_ENTRIES > 1) ? $clog2(PACKET_BUFFER_NUM_ENTRIES) : 1;
  typedef logic [SEL_W-1:0] sel_t;

  serializer_state_t           r_state;
  tail_index_t                 r_idx;
  tail_index_t                 r_tail;
  packet_id_t                  r_pkt_id;
  flit_t [PKT_BUF_ENTRIES-1:0] r_buf;
  flit_t                       r_flit;
  logic                        r_flit_valid;
  logic                        r_packet_sent;
  packet_id_t                  r_sent_pkt_id;
  logic                        r_tx_error;

  logic        w_accept;
  logic        w_pkt_ok;
  logic        w_hs;
  logic        w_last;
  tail_index_t w_idx_next;

`ifdef FLIT_SERIALIZER_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] r_stall_cnt;
`else
  // TIMEOUT_CYCLES only shapes behaviour when the timeout is compiled in.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  assign w_accept   = bus.packet_valid && (r_state == IDLE);
  assign w_pkt_ok   = bus.packet.is_complete
                   && (bus.packet.tail_index != '0)
                   && (bus.packet.tail_index <= tail_index_t'(PACKET_BUFFER_NUM_ENTRIES));
  assign w_hs       = r_flit_valid && bus.flit_ready;
  assign w_last     = (r_idx == (r_tail - tail_index_t'(1)));
  assign w_idx_next = r_idx + tail_index_t'(1);

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_tail        <= '0;
      r_pkt_id      <= '0;
      r_buf         <= '0;
      r_flit        <= '0;
      r_flit_valid  <= 1'b0;
      r_packet_sent <= 1'b0;
      r_sent_pkt_id <= '0;
      r_tx_error    <= 1'b0;
`ifdef FLIT_SERIALIZER_TIMEOUT_EN
      r_stall_cnt   <= '0;
`endif
    end else begin
      r_packet_sent <= 1'b0;
      r_tx_error    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_pkt_ok) begin
              r_buf        <= bus.packet.buffer;
              r_tail       <= bus.packet.tail_index;
              r_pkt_id     <= bus.packet.packet_id;
              r_idx        <= '0;
              r_flit       <= bus.packet.buffer[0];
              r_flit_valid <= 1'b1;
              r_state      <= SEND;
`ifdef FLIT_SERIALIZER_TIMEOUT_EN
              r_stall_cnt  <= '0;
`endif
            end else begin
              r_tx_error   <= 1'b1;
            end
          end
        end
        SEND: begin
          if (w_hs) begin
`ifdef FLIT_SERIALIZER_TIMEOUT_EN
            r_stall_cnt <= '0;
`endif
            if (w_last) begin
              r_flit_valid  <= 1'b0;
              r_packet_sent <= 1'b1;
              r_sent_pkt_id <= r_pkt_id;
              r_idx         <= '0;
              r_state       <= IDLE;
            end else begin
              // Preload the next flit on the handshake edge so there is no bubble.
              r_idx  <= w_idx_next;
              r_flit <= r_buf[sel_t'(w_idx_next)];
            end
          end
`ifdef FLIT_SERIALIZER_TIMEOUT_EN
          else if (r_stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            r_flit_valid <= 1'b0;
            r_tx_error   <= 1'b1;
            r_idx        <= '0;
            r_stall_cnt  <= '0;
            r_state      <= IDLE;
          end else begin
            r_stall_cnt  <= r_stall_cnt + STALL_W'(1);
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.packet_ready = (r_state == IDLE);
  assign bus.flit         = r_flit;
  assign bus.flit_valid   = r_flit_valid;
  assign bus.packet_sent  = r_packet_sent;
  assign bus.sent_pkt_id  = r_sent_pkt_id;
  assign bus.tx_error     = r_tx_error;

endmodule
